// File: rtl/bus_master_if.sv
// Host command port plus register-bus wires for the bus initiator.
// Bus layout: bus_in = {clk, reset_l, addr, re, we, wr_data}; bus_out = {rd_data, rd_ack, wr_ack, irq}.
// master = initiator view, slave = host/bus-side view (testbench or bridge).
interface bus_master_if #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_DATA_WIDTH = 32
);
    localparam int BUS_IN_WIDTH  = BUS_ADDR_WIDTH + BUS_DATA_WIDTH + 4;
    localparam int BUS_OUT_WIDTH = BUS_DATA_WIDTH + 3;

    logic [BUS_IN_WIDTH-1:0]   bus_in;
    logic [BUS_OUT_WIDTH-1:0]  bus_out;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [BUS_ADDR_WIDTH-1:0] req_addr;
    logic [BUS_DATA_WIDTH-1:0] req_wr_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [BUS_DATA_WIDTH-1:0] rsp_rd_data;
    logic                      rsp_err;
    logic                      irq;

    modport master (
        output bus_in, req_ready, rsp_valid, rsp_rd_data, rsp_err, irq,
        input  bus_out, req_valid, req_we, req_addr, req_wr_data, rsp_ready
    );

    modport slave (
        input  bus_in, req_ready, rsp_valid, rsp_rd_data, rsp_err, irq,
        output bus_out, req_valid, req_we, req_addr, req_wr_data, rsp_ready
    );
endinterface

// File: rtl/bus_master.sv
// Register-bus initiator: one host read/write at a time, single-cycle strobe, waits for ack or times out.
// Latency: request accepted cycle 0, strobe cycle 1, earliest ack cycle 2, rsp_valid cycle 3.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module bus_master #(
    parameter int TIMEOUT        = 255,
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_DATA_WIDTH = 32
) (
    input  logic           bus_clk,
    input  logic           bus_reset,
    bus_master_if.master   bus
);
    localparam int AW = BUS_ADDR_WIDTH;
    localparam int DW = BUS_DATA_WIDTH;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    // bus_out field positions
    localparam int IRQ_BIT    = 0;
    localparam int WR_ACK_BIT = 1;
    localparam int RD_ACK_BIT = 2;
    localparam int RD_DAT_LSB = 3;

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            is_wr_q, is_wr_d;
    logic            re_q, re_d;
    logic            we_q, we_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rd_data_q, rsp_rd_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            irq_q, irq_d;

    logic            ack_match;
    logic            unused_addr_bits;

    // Byte-lane bits of the host address never reach the bus.
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // Only the ack matching the latched transaction type counts.
    assign ack_match = is_wr_q ? bus.bus_out[WR_ACK_BIT] : bus.bus_out[RD_ACK_BIT];

    // Next-state and next-output logic for the request/strobe/wait/response sequence.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        is_wr_d       = is_wr_q;
        re_d          = re_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rd_data_d = rsp_rd_data_q;
        rsp_err_d     = rsp_err_q;
        irq_d         = bus.bus_out[IRQ_BIT];

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = {bus.req_addr[AW-1:2], 2'b00};
                    wdata_d = bus.req_wr_data;
                    is_wr_d = bus.req_we;
                    re_d    = ~bus.req_we;
                    we_d    = bus.req_we;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                re_d    = 1'b0;
                we_d    = 1'b0;
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ack_match) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_rd_data_d = is_wr_q ? '0 : bus.bus_out[RD_DAT_LSB +: DW];
                    state_d       = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_rd_data_d = '1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any transaction and drops strobes immediately.
    always_ff @(posedge bus_clk or posedge bus_reset) begin
        if (bus_reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            is_wr_q       <= 1'b0;
            re_q          <= 1'b0;
            we_q          <= 1'b0;
            cnt_q         <= 16'd0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_data_q <= '0;
            rsp_err_q     <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            is_wr_q       <= is_wr_d;
            re_q          <= re_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rd_data_q <= rsp_rd_data_d;
            rsp_err_q     <= rsp_err_d;
            irq_q         <= irq_d;
        end
    end

    assign bus.bus_in      = {bus_clk, ~bus_reset, addr_q, re_q, we_q, wdata_q};
    assign bus.req_ready   = (state_q == S_IDLE) & ~bus_reset;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.irq         = irq_q;
endmodule
